// File: rtl/avalon_st_sink_fifo.sv
`default_nettype none
// ============================================================================
// Module  : avalon_st_sink_fifo
// Brief   : Ready-latency-1 Avalon-ST sink into a show-ahead FIFO with debug stats
// Revision: 1.0
// ============================================================================
module avalon_st_sink_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sink_en,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic [15:0] beat_count,
    output logic [7:0]  checksum,
    output logic        proto_err
);

    localparam logic [AW:0]   C_DEPTH  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   C_HI_WM  = (AW+1)'(DEPTH - 2);
    localparam logic [AW:0]   C_CNT1   = (AW+1)'(1);
    localparam logic [AW-1:0] C_PTR1   = AW'(1);

    typedef enum logic {
        ST_STALL = 1'b0,
        ST_READY = 1'b1
    } rdy_state_e;

    rdy_state_e        rdy_state_q, rdy_state_d;
    logic              rdy_prev_q,  rdy_prev_d;
    logic [AW:0]       count_q,     count_d;
    logic [AW-1:0]     rd_ptr_q,    rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q,    wr_ptr_d;
    logic [7:0]        out_data_q,  out_data_d;
    logic [15:0]       beat_count_q, beat_count_d;
    logic [7:0]        checksum_q,  checksum_d;
    logic              proto_err_q, proto_err_d;
    logic [7:0]        mem_q [DEPTH];

    logic              w_full;
    logic              w_pop;
    logic              w_wr_en;

    always_comb begin
        w_full       = (count_q == C_DEPTH);
        w_pop        = (count_q != '0) && out_ready;
        // A full FIFO still takes a beat when the head leaves on the same edge
        w_wr_en      = in_valid && (!w_full || w_pop);

        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        out_data_d   = out_data_q;
        beat_count_d = beat_count_q;
        checksum_d   = checksum_q;
        proto_err_d  = proto_err_q;

        case ({w_wr_en, w_pop})
            2'b10:   count_d = count_q + C_CNT1;
            2'b01:   count_d = count_q - C_CNT1;
            default: count_d = count_q;
        endcase

        if (w_wr_en) begin
            wr_ptr_d     = wr_ptr_q + C_PTR1;
            beat_count_d = beat_count_q + 16'd1;
            checksum_d   = checksum_q + in_data;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR1;
        end

        // Upstream launches on the ready it saw one cycle before the push edge
        if (in_valid && (!rdy_prev_q || !w_wr_en)) begin
            proto_err_d = 1'b1;
        end

        rdy_state_d = (sink_en && (count_d <= C_HI_WM)) ? ST_READY : ST_STALL;
        rdy_prev_d  = (rdy_state_q == ST_READY);

        // The new head may be the beat being written at this very edge
        if (count_d != '0) begin
            out_data_d = (w_wr_en && (wr_ptr_q == rd_ptr_d)) ? in_data : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdy_state_q  <= ST_STALL;
            rdy_prev_q   <= 1'b0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            out_data_q   <= 8'd0;
            beat_count_q <= 16'd0;
            checksum_q   <= 8'd0;
            proto_err_q  <= 1'b0;
        end else begin
            rdy_state_q  <= rdy_state_d;
            rdy_prev_q   <= rdy_prev_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            out_data_q   <= out_data_d;
            beat_count_q <= beat_count_d;
            checksum_q   <= checksum_d;
            proto_err_q  <= proto_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign in_ready   = (rdy_state_q == ST_READY);
    assign out_valid  = (count_q != '0);
    assign out_data   = out_data_q;
    assign beat_count = beat_count_q;
    assign checksum   = checksum_q;
    assign proto_err  = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_avalon_st_sink_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_avalon_st_sink_fifo
// Brief   : Scoreboard bench for avalon_st_sink_fifo against a queue-based model
// Revision: 1.0
// ============================================================================
module tb_avalon_st_sink_fifo;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        sink_en = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [15:0] beat_count;
    logic [7:0]  checksum;
    logic        proto_err;

    int checks = 0;
    int errors = 0;

    avalon_st_sink_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .sink_en    (sink_en),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .beat_count (beat_count),
        .checksum   (checksum),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference model: occupancy as an integer, accepted beats appended to a queue
    logic [7:0]  exp_q[$];
    int          m_cnt;
    logic [15:0] m_beats;
    logic [7:0]  m_sum;
    logic        m_err;
    logic        m_rdy;
    logic        m_rdy_prev;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exp_q.delete();
            m_cnt = 0; m_beats = 0; m_sum = 0; m_err = 0; m_rdy = 0; m_rdy_prev = 0;
        end else begin
            logic pop, acc;
            pop = (m_cnt != 0) && out_ready;
            acc = in_valid && ((m_cnt < DEPTH) || pop);
            if (in_valid && (!m_rdy_prev || !acc)) m_err = 1'b1;
            if (acc) begin
                exp_q.push_back(in_data);
                m_beats = m_beats + 16'd1;
                m_sum   = m_sum + in_data;
            end
            m_cnt      = m_cnt + (acc ? 1 : 0) - (pop ? 1 : 0);
            m_rdy_prev = m_rdy;
            m_rdy      = sink_en && (m_cnt <= DEPTH - 2);
        end
    end

    // Monitor: consumes expected beats in order as the DUT hands them over
    int         rd_idx = 0;
    logic [7:0] last_pop = 8'd0;

    always @(negedge clk) begin
        if (!resetn) begin
            rd_idx   = 0;
            last_pop = 8'd0;
        end else begin
            chk("out_valid", out_valid, (exp_q.size() > rd_idx));
            if (out_valid && exp_q.size() > rd_idx)
                chk("out_data_head", out_data, exp_q[rd_idx]);
            else if (!out_valid)
                chk("out_data_hold", out_data, last_pop);
            chk("in_ready", in_ready, m_rdy);
            chk("beat_count", beat_count, m_beats);
            chk("checksum", checksum, m_sum);
            chk("proto_err", proto_err, m_err);
            if (out_valid && out_ready && exp_q.size() > rd_idx) begin
                last_pop = exp_q[rd_idx];
                rd_idx++;
            end
        end
    end

    // in_ready as the upstream saw it during the cycle that just ended
    logic up_rdy_seen = 1'b0;
    always @(posedge clk) up_rdy_seen <= in_ready;

    logic rnd_ordy = 1'b0;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        in_valid = v;
        in_data  = v ? d : 8'($urandom);
        if (rnd_ordy) out_ready = 1'($urandom_range(0, 1));
        step();
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        for (int i = 0; i < 64; i++) begin
            if (up_rdy_seen) begin
                drive(1'b1, d);
                return;
            end
            drive(1'b0, 8'd0);
        end
        chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        resetn   = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_beat_count", beat_count, 16'd0);
        chk("rst_checksum", checksum, 8'd0);
        chk("rst_proto_err", proto_err, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        step();
        step();
        resetn = 1'b1;
    endtask

    initial begin
        step();
        step();
        sink_en   = 1'b1;
        out_ready = 1'b1;
        do_reset();
        step();
        chk("ready_after_release", in_ready, 1'b1);

        send(8'd4); send(8'd5); send(8'd6);
        repeat (3) drive(1'b0, 8'd0);
        chk("p1_beats", beat_count, 16'd3);
        chk("p1_sum", checksum, 8'd15);
        chk("p1_err", proto_err, 1'b0);

        // Backpressure: fourth beat arrives after in_ready has already dropped
        out_ready = 1'b0;
        send(8'h10); send(8'h11); send(8'h12); send(8'h13);
        repeat (2) drive(1'b0, 8'd0);
        chk("p2_full_valid", out_valid, 1'b1);
        chk("p2_err", proto_err, 1'b0);
        chk("p2_stall", in_ready, 1'b0);
        out_ready = 1'b1;
        repeat (8) drive(1'b0, 8'd0);
        chk("p2_beats", beat_count, 16'd7);
        chk("p2_sum", checksum, 8'd85);

        // Full with no pop: beat dropped
        do_reset();
        out_ready = 1'b0;
        send(8'hA0); send(8'hA1); send(8'hA2); send(8'hA3);
        drive(1'b1, 8'hEE);
        chk("p3_drop_beats", beat_count, 16'd4);
        chk("p3_drop_err", proto_err, 1'b1);
        // Full with simultaneous pop: beat accepted
        do_reset();
        out_ready = 1'b0;
        send(8'hB0); send(8'hB1); send(8'hB2); send(8'hB3);
        out_ready = 1'b1;
        drive(1'b1, 8'hB4);
        out_ready = 1'b0;
        chk("p3_fullpop_beats", beat_count, 16'd5);
        chk("p3_fullpop_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        repeat (6) drive(1'b0, 8'd0);

        // Push while in_ready has been low
        do_reset();
        repeat (3) drive(1'b0, 8'd0);
        sink_en = 1'b0;
        repeat (3) drive(1'b0, 8'd0);
        drive(1'b1, 8'h77);
        drive(1'b0, 8'd0);
        chk("p4_err", proto_err, 1'b1);
        chk("p4_beats", beat_count, 16'd1);
        chk("p4_sum", checksum, 8'h77);
        sink_en = 1'b1;

        // Pointer wrap with random output backpressure
        do_reset();
        rnd_ordy = 1'b1;
        for (int i = 1; i <= 10; i++) send(8'(i));
        rnd_ordy  = 1'b0;
        out_ready = 1'b1;
        repeat (10) drive(1'b0, 8'd0);
        chk("p5_beats", beat_count, 16'd10);
        chk("p5_sum", checksum, 8'd55);
        chk("p5_empty", out_valid, 1'b0);

        // Reset with data buffered
        do_reset();
        out_ready = 1'b0;
        send(8'd1); send(8'd2);
        chk("p6_buffered", out_valid, 1'b1);
        do_reset();
        step();
        chk("p6_ready_after_release", in_ready, 1'b1);

        // Random traffic with occasional protocol violations and one mid-run reset
        for (int i = 0; i < 400; i++) begin
            logic v;
            if (i == 200) do_reset();
            sink_en   = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            v = (up_rdy_seen && ($urandom_range(0, 1) == 1)) || ($urandom_range(0, 39) == 0);
            drive(v, 8'($urandom));
        end
        sink_en   = 1'b1;
        out_ready = 1'b1;
        repeat (8) drive(1'b0, 8'd0);
        chk("final_empty", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/avalon_st_sink_fifo.md
Name: avalon_st_sink_fifo

Overview:
- Downstream consumer of the byte-wide Avalon-ST source stage, which uses ready latency 1 (it samples `ready`, then drives `valid`/`data` on the next cycle).
- Drives `in_ready`, absorbs beats into a DEPTH-entry FIFO and re-presents them on a ready-latency-0 output stream.
- Keeps a beat counter, a running byte checksum and a sticky protocol-error flag for bring-up and debug.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- AW, 2, pointer width, equal to log2(DEPTH).

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  reset, asynchronous, active-low.
- sink_en  input  1  high enables acceptance; low forces in_ready low from the next edge.
- in_valid  input  1  upstream beat valid; ready latency 1.
- in_data  input  8  upstream beat data; ignored (may be X) when in_valid=0.
- in_ready  output  1  registered ready to upstream.
- out_valid  output  1  FIFO non-empty.
- out_data  output  8  FIFO head (show-ahead).
- out_ready  input  1  downstream accept; ready latency 0.
- beat_count  output  16  total beats written, wraps at 65535->0.
- checksum  output  8  sum of written bytes, mod 256.
- proto_err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (async assert, sync release): in_ready=0, out_valid=0, out_data=0, count=0, rd_ptr=wr_ptr=0, beat_count=0, checksum=0, proto_err=0. FIFO storage is not reset.
- Transfer definitions:
  - Push: in_valid=1 at a rising edge. Ready latency 1 means in_ready is not qualified in the push cycle.
  - Pop: out_valid=1 and out_ready=1 at a rising edge.
- in_ready rule (registered): in_ready <= sink_en && (count_next <= DEPTH-2), where count_next is the occupancy after this edge's push/pop. This guarantees one free slot for a beat launched by ready asserted one cycle earlier.
- Push acceptance:
  - Written when count<DEPTH, or count==DEPTH with a pop at the same edge.
  - Accepted beat: mem[wr_ptr]<=in_data, wr_ptr+1 (wraps modulo DEPTH), beat_count+1, checksum+in_data.
- Protocol errors (proto_err<=1, sticky until reset):
  - Push while in_ready was 0 in the previous cycle. The beat is still written if space exists.
  - Push when full with no pop. The beat is dropped; beat_count and checksum are unchanged.
- Pop: rd_ptr+1 (wraps modulo DEPTH).
- Occupancy: count changes by +1 on push-only, -1 on pop-only, unchanged on simultaneous push and pop (including the full and empty cases).
- Output side:
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr] when count != 0, else holds its last value. No zero-latency bypass: a beat written at edge N appears on out_valid after edge N.
- Latency: in_valid beat at edge N -> out_valid high from edge N until popped.
- sink_en low: in_ready drops after the next edge. Beats already in flight (one cycle) are still accepted without error. FIFO keeps draining.
- Reset mid-operation: all state returns to reset values immediately; buffered data is lost; in_ready returns to 1 one edge after release, if sink_en=1.
- No internal state machine beyond FIFO occupancy; in_ready behaves as the two states READY and STALL, selected by the threshold rule above.

Test Plan:
- Release reset with sink_en=1, out_ready=1; upstream sends 4,5,6 -> in_ready=1 one edge after release; out_data sequence 4,5,6, each one cycle after its push; beat_count=3, checksum=15, proto_err=0.
- out_ready=0, continuous beats 0x10..0x13, DEPTH=4 -> in_ready falls when count reaches 3; the in-flight beat fills slot 4; no drop, proto_err=0; then out_ready=1 -> 0x10,0x11,0x12,0x13 drain in order and in_ready returns once count<=2.
- Full FIFO, in_valid=1 and out_ready=1 at the same edge -> push accepted, count stays 4, head advances; force in_valid=1 while full with out_ready=0 -> beat dropped, proto_err=1, beat_count unchanged.
- in_valid pulse while in_ready has been 0 (sink_en=0 for two cycles) -> proto_err=1; byte written since space exists.
- 10 beats 1..10 with random out_ready -> pointers wrap; output order 1..10; beat_count=10, checksum=55.
- Assert resetn low after 2 of 3 beats buffered -> out_valid=0, count=0, beat_count=0, checksum=0 immediately; in_ready=1 one edge after release.
